// File: rtl/seq_divider.sv
// Restoring sequential divider returning MIPS div/divu results (HI=rem, LO=quot).
// Optional DIV_EARLY_OUT_EN: skip iterations when |a| < |b|.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;

  logic             sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;

  // Operand magnitudes and one restoring step, shared by the FSM below.
  always_comb begin
    sa      = sign_mode & a[WIDTH-1];
    sb      = sign_mode & b[WIDTH-1];
    a_mag   = sa ? ('0 - a) : a;
    b_mag   = sb ? ('0 - b) : b;
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
  end

  // State and datapath registers; reset aborts any in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state, datapath updates and status outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (b == '0) begin
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            dz_d    = 1'b0;
            dvs_d   = b_mag;
            qsign_d = sa ^ sb;
            rsign_d = sa;
            cnt_d   = '0;
`ifdef DIV_EARLY_OUT_EN
            if (a_mag < b_mag) begin
              rem_d   = a_mag;
              quo_d   = '0;
              state_d = FIX;
            end else begin
              rem_d   = '0;
              quo_d   = a_mag;
              state_d = CALC;
            end
`else
            rem_d   = '0;
            quo_d   = a_mag;
            state_d = CALC;
`endif
          end
        end
      end
      CALC: begin
        busy = 1'b1;
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        busy    = 1'b1;
        lo_d    = qsign_q ? ('0 - quo_q) : quo_q;
        hi_d    = rsign_q ? ('0 - rem_q) : rem_q;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random
// operands checked against plain-arithmetic MIPS div/divu model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sign_mode = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int fails = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .sign_mode(sign_mode),
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: language division truncates toward zero, remainder
  // follows the dividend; 64-bit math makes MIN/-1 exact before wrap.
  task automatic model(input logic sm, input logic [31:0] x,
                       input logic [31:0] y, output logic [31:0] q,
                       output logic [31:0] r, output int lat);
    longint sx, sy, ax, ay;
    if (sm) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'b0, x});
      sy = longint'({32'b0, y});
    end
    ax = (sx < 0) ? -sx : sx;
    ay = (sy < 0) ? -sy : sy;
    if (y == 32'd0) begin
      q = exp_lo;
      r = exp_hi;
      lat = 0;
    end else begin
      q = 32'(sx / sy);
      r = 32'(sx % sy);
      lat = 33;
`ifdef DIV_EARLY_OUT_EN
      if (ax < ay) lat = 1;
`endif
    end
  endtask

  // Issue one request and check latency, busy span, results, pulse width.
  task automatic run_op(input string tag, input logic sm,
                        input logic [31:0] x, input logic [31:0] y);
    logic [31:0] q, r;
    int lat, k, nbusy;
    bit seen;
    model(sm, x, y, q, r, lat);
    @(negedge clk);
    sign_mode = sm; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = $urandom; b = $urandom;
    k = 0; nbusy = 0; seen = 0;
    while (k < 100) begin
      if (done) begin seen = 1; break; end
      if (busy) nbusy++;
      @(posedge clk); #1;
      k++;
    end
    check({tag, ":done_seen"}, 32'(seen), 32'd1);
    check({tag, ":latency"}, 32'(k), 32'(lat));
    check({tag, ":busy_cycles"}, 32'(nbusy), 32'((lat == 0) ? 0 : lat));
    check({tag, ":div_zero"}, 32'(div_zero), 32'(y == 32'd0));
    check({tag, ":lo"}, lo, q);
    check({tag, ":hi"}, hi, r);
    exp_lo = q; exp_hi = r;
    @(posedge clk); #1;
    check({tag, ":done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [31:0] q, r, ra, rb;
    int lat, k, ndone;
    repeat (2) @(posedge clk);
    #1;
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:dz", 32'(div_zero), 32'd0);
    check("rst:hi", hi, 32'd0);
    check("rst:lo", lo, 32'd0);
    @(negedge clk) reset = 1'b0;

    run_op("t1", 1'b1, 32'd100, 32'd7);
    run_op("t3_dz", 1'b0, 32'd5, 32'd0);
    run_op("t2s", 1'b1, 32'hFFFF_FFF9, 32'd2);
    check("t3:dz_clear", 32'(div_zero), 32'd0);
    run_op("t2u", 1'b0, 32'hFFFF_FFF9, 32'd2);
    run_op("t4s", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("t4u", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("t6", 1'b1, 32'd3, 32'd10);
    run_op("neg_div", 1'b1, 32'd100, 32'hFFFF_FFF9);
    run_op("umax", 1'b0, 32'hFFFF_FFFF, 32'd1);

    // Second start mid-CALC must be ignored: exactly one done.
    model(1'b1, 32'd1000, 32'd33, q, r, lat);
    @(negedge clk);
    sign_mode = 1'b1; a = 32'd1000; b = 32'd33; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 a = 32'd7; b = 32'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    check("t5:one_done", 32'(ndone), 32'd1);
    check("t5:lo", lo, q);
    check("t5:hi", hi, r);
    check("t5:dz", 32'(div_zero), 32'd0);

    // Reset mid-operation aborts without a done.
    @(negedge clk);
    sign_mode = 1'b0; a = 32'd50; b = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("t5r:busy", 32'(busy), 32'd0);
    check("t5r:hi", hi, 32'd0);
    check("t5r:lo", lo, 32'd0);
    @(negedge clk) reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("t5r:no_done", 32'(ndone), 32'd0);
    run_op("t5r_after", 1'b0, 32'd50, 32'd3);

    // Random operands, with some small divisors, zeros and tiny dividends.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      k = $urandom_range(0, 5);
      if (k == 0) rb = 32'(signed'($urandom_range(0, 15)) - 8);
      if (k == 1) rb = 32'd0;
      if (k == 2) ra = 32'($urandom_range(0, 100));
      run_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), ra, rb);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
